// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU, device and memory-side signals of the memory arbiter
// Ports: none; the signals are grouped into two modports.
//   slave  - arbiter view: takes cpu_*/dev_* requests and mem_rdata; drives strobes, read data, mem_* and busy
//   master - environment view: the same signals with directions reversed
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              cpu_req, cpu_we, cpu_r;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              dev_req, dev_we, dev_ack;
    logic [ADDR_W-1:0] dev_addr;
    logic [DATA_W-1:0] dev_wdata, dev_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              busy;
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_r,
        input  dev_req, dev_we, dev_addr, dev_wdata,
        output dev_rdata, dev_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_r,
        output dev_req, dev_we, dev_addr, dev_wdata,
        input  dev_rdata, dev_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the LC-3 CPU and one device master
// Ports:
//   clk   - system clock, all state on posedge
//   rst_n - asynchronous active-low reset
//   bus   - mem_arbiter_if.slave: cpu_req/we/addr/wdata in, cpu_rdata/cpu_r out;
//           dev_req/we/addr/wdata in, dev_rdata/dev_ack out;
//           mem_en/we/addr/wdata out, mem_rdata in; busy out
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 4,
    parameter int STARVE  = 4
) (
    input logic clk,
    input logic rst_n,
    mem_arbiter_if.slave bus
);
    localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
    localparam int SW = $clog2(STARVE + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);
    typedef enum logic [2:0] {IDLE, CPU_ACC, DEV_ACC, CPU_DONE, DEV_DONE} state_t;
    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic [SW-1:0]     starve;
    logic              we_q, grant_cpu, grant_dev, last;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, cpu_rdata_q, dev_rdata_q;

    assign last = cnt == '0;

    // CPU wins ties unless the device has already been passed over STARVE times
    always_comb begin
        state_nx  = state;
        grant_cpu = 1'b0;
        grant_dev = 1'b0;
        case (state)
            IDLE: begin
                grant_dev = bus.dev_req && (!bus.cpu_req || starve == STARVE_MAX);
                grant_cpu = bus.cpu_req && !grant_dev;
                state_nx  = grant_cpu ? CPU_ACC : grant_dev ? DEV_ACC : IDLE;
            end
            CPU_ACC: state_nx = last ? CPU_DONE : CPU_ACC;
            DEV_ACC: state_nx = last ? DEV_DONE : DEV_ACC;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            starve      <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dev_rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (grant_cpu || grant_dev) begin
                cnt     <= CNT_INIT;
                we_q    <= grant_cpu ? bus.cpu_we : bus.dev_we;
                addr_q  <= grant_cpu ? bus.cpu_addr : bus.dev_addr;
                wdata_q <= grant_cpu ? bus.cpu_wdata : bus.dev_wdata;
            end else if (!last) begin
                cnt <= cnt - 1'b1;
            end
            if (state == CPU_ACC && last && !we_q) cpu_rdata_q <= bus.mem_rdata;
            if (state == DEV_ACC && last && !we_q) dev_rdata_q <= bus.mem_rdata;
            if (grant_dev || (state == IDLE && !bus.dev_req)) starve <= '0;
            else if (grant_cpu && starve != STARVE_MAX) starve <= starve + 1'b1;
        end
    end

    assign bus.mem_en    = state == CPU_ACC || state == DEV_ACC;
    assign bus.mem_we    = bus.mem_en && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_r     = state == CPU_DONE;
    assign bus.dev_ack   = state == DEV_DONE;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dev_rdata = dev_rdata_q;
    assign bus.busy      = state != IDLE;
endmodule
